vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Sits directly downstream of the 25 MHz pixel-clock PLL wrapper and runs in the pixel-clock domain.
- Qualifies the PLL lock, then releases a synchronous video reset once lock is stable.
- Generates 640x480@60 VGA timing for the game renderer and the VGA output pins: hsync, vsync, data-enable, pixel coordinates and frame/line strobes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low), applies to both syncs
- LOCK_WAIT, 1024, consecutive locked cycles required before RUN (>=1)
- CW, 10, width of x/y counters

Ports:
- clock  in  1  25 MHz pixel clock from the PLL wrapper
- reset  in  1  synchronous, active-high
- pll_locked  in  1  PLL lock indicator, treated as synchronous to clock
- video_rst  out  1  synchronous active-high reset for downstream video logic
- hsync  out  1  horizontal sync at SYNC_POL level when active
- vsync  out  1  vertical sync at SYNC_POL level when active
- de  out  1  high during visible pixels
- x  out  CW  horizontal counter, 0..H_TOTAL-1
- y  out  CW  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when x==0 in RUN
- frame_start  out  1  one-cycle pulse when x==0 and y==0 in RUN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- All outputs are registered. Counters and decoded outputs update in the same edge, so they are mutually consistent every cycle. There is no extra pipeline latency between x/y and de/hsync/vsync.
- State machine: WAIT_LOCK -> STABLE -> RUN.
  - WAIT_LOCK: lock_cnt=0. Goes to STABLE when pll_locked=1.
  - STABLE: lock_cnt increments each cycle while pll_locked=1. If pll_locked=0, return to WAIT_LOCK and clear lock_cnt. When lock_cnt reaches LOCK_WAIT-1 with pll_locked=1, go to RUN next edge.
  - RUN: counters run. If pll_locked=0, go to WAIT_LOCK next edge. Outputs return to idle values on that same edge.
- Idle/reset values (reset=1, or any non-RUN state):
  - video_rst=1, de=0, x=0, y=0, line_start=0, frame_start=0
  - hsync=vsync=~SYNC_POL (inactive)
- First RUN cycle:
  - x=0, y=0, video_rst=0, line_start=1, frame_start=1
  - de=1 (pixel (0,0) is visible)
- Counting:
  - x increments each cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, y increments and wraps V_TOTAL-1 -> 0. No other y change.
- Decode, from the current x/y:
  - de = (x<H_ACTIVE) && (y<V_ACTIVE)
  - hsync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line including x=0
- Boundary conditions:
  - reset overrides everything, including pll_locked=1; state goes to WAIT_LOCK.
  - reset deasserted with pll_locked already 1: the full LOCK_WAIT count still applies.
  - Lock loss at any x/y, mid-line or mid-frame: immediate idle, no completion of the line or frame.
  - Re-entering RUN always starts at (0,0).
  - Counters never exceed H_TOTAL-1 / V_TOTAL-1.
  - CW must hold max(H_TOTAL, V_TOTAL)-1. A parameter check fails elaboration otherwise.

Test Plan:
1. Reset release, LOCK_WAIT=8, pll_locked=1 from cycle 0 -> video_rst=1 for exactly 9 edges after reset drops (1 WAIT_LOCK + 8 STABLE). Then video_rst=0, frame_start=1, x=0, y=0, de=1.
2. Lock glitch: pll_locked low for 1 cycle after 5 STABLE cycles -> lock_cnt restarts. RUN is entered 8 locked cycles after the glitch, not earlier.
3. Line timing in RUN, y=0:
   - de=1 for x=0..639, 0 at x=640..799
   - hsync low exactly at x=656..751, 96 cycles
   - line_start every 800 cycles
4. Frame timing:
   - vsync low for exactly 1600 cycles, lines 490..491
   - de never high for y>=480
   - frame_start period = 420000 cycles
   - y wraps 524 -> 0 together with x 799 -> 0
5. Lock loss at x=300, y=200 -> next edge: video_rst=1, de=0, hsync=vsync=1, x=y=0. Relock plus LOCK_WAIT -> restarts at (0,0) with frame_start=1.
6. reset=1 asserted during RUN at x=700 (inside hsync) -> next edge all idle values, hsync=1. reset dominates a simultaneous pll_locked=1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen_if
// Brief  : Video timing bundle from the timing generator to renderer and pins.
// Rev    : 1.0
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          video_rst;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output video_rst, hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input  video_rst, hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Brief  : PLL-lock qualifier and 640x480@60 VGA timing generator.
// Rev    : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int LOCK_WAIT = 1024,
    parameter int CW        = 10
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       pll_locked,
    vga_timing_gen_if.master vga
);

    localparam int c_h_total   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_max_total = (c_h_total > c_v_total) ? c_h_total : c_v_total;
    localparam int c_lw        = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [CW-1:0]   c_h_last     = CW'(c_h_total - 1);
    localparam logic [CW-1:0]   c_v_last     = CW'(c_v_total - 1);
    localparam logic [CW-1:0]   c_h_active   = CW'(H_ACTIVE);
    localparam logic [CW-1:0]   c_v_active   = CW'(V_ACTIVE);
    localparam logic [CW-1:0]   c_hs_start   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]   c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0]   c_vs_start   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]   c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_lw-1:0] c_lock_last  = c_lw'(LOCK_WAIT - 1);

    generate
        if ((2 ** CW) < c_max_total || LOCK_WAIT < 1) begin : g_param_check
            $error("vga_timing_gen: CW too narrow for the frame geometry or LOCK_WAIT < 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_lw-1:0] r_lock_cnt;
    logic [c_lw-1:0] w_lock_cnt_nxt;
    logic            w_run_nxt;
    logic [CW-1:0]   w_x_nxt;
    logic [CW-1:0]   w_y_nxt;

    logic            r_video_rst;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic            r_line_start;
    logic            r_frame_start;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_WAIT_LOCK;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = '0;
        w_x_nxt        = '0;
        w_y_nxt        = '0;

        case (r_state)
            ST_WAIT_LOCK: begin
                if (pll_locked) w_state_nxt = ST_STABLE;
            end
            ST_STABLE: begin
                if (!pll_locked)
                    w_state_nxt = ST_WAIT_LOCK;
                else if (r_lock_cnt == c_lock_last)
                    w_state_nxt = ST_RUN;
                else
                    w_lock_cnt_nxt = r_lock_cnt + c_lw'(1);
            end
            ST_RUN: begin
                if (!pll_locked) w_state_nxt = ST_WAIT_LOCK;
            end
            default: w_state_nxt = ST_WAIT_LOCK;
        endcase

        w_run_nxt = (w_state_nxt == ST_RUN);

        // Entering RUN leaves the counters at (0,0); only a continuing RUN advances them.
        if (w_run_nxt && r_state == ST_RUN) begin
            if (r_x == c_h_last) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == c_v_last) ? '0 : r_y + CW'(1);
            end else begin
                w_x_nxt = r_x + CW'(1);
                w_y_nxt = r_y;
            end
        end
    end

    // Decode from the next counter values so x/y and the strobes share one edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_video_rst   <= 1'b1;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_video_rst   <= ~w_run_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_de          <= w_run_nxt && (w_x_nxt < c_h_active) && (w_y_nxt < c_v_active);
            r_hsync       <= (w_run_nxt && (w_x_nxt >= c_hs_start) && (w_x_nxt < c_hs_end))
                             ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_run_nxt && (w_y_nxt >= c_vs_start) && (w_y_nxt < c_vs_end))
                             ? SYNC_POL : ~SYNC_POL;
            r_line_start  <= w_run_nxt && (w_x_nxt == '0);
            r_frame_start <= w_run_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
        end
    end

    assign vga.video_rst   = r_video_rst;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.de          = r_de;
    assign vga.x           = r_x;
    assign vga.y           = r_y;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Scoreboard bench for vga_timing_gen with a shortened vertical frame.
// Rev    : 1.0
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int VA = 12,  VF = 2,  VS = 2,  VB = 2,  VT = 18;
    localparam int FRAME = HT * VT;   // 14400
    localparam logic [25:0] IDLE = {1'b1, 1'b1, 1'b1, 1'b0, 20'd0, 2'b00};

    typedef struct {
        int          cyc;
        int          tag;
        logic [25:0] v;
    } exp_t;

    logic clock;
    logic reset;
    logic pll_locked;
    int   cyc;
    int   checks;
    int   errors;
    int   px, py;
    int   win_lo, win_hi;
    int   n_hs, n_vs, n_de, n_ls, n_fs, last_fs, fs_period;
    exp_t exp_q[$];
    exp_t me;
    logic [25:0] got;

    vga_timing_gen_if #(.CW(10)) vga ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0), .LOCK_WAIT (8), .CW (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .vga        (vga)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    assign got = {vga.video_rst, vga.hsync, vga.vsync, vga.de,
                  vga.x, vga.y, vga.line_start, vga.frame_start};

    // Monitor: outputs are presented every cycle; compare against the queued entry for this cycle.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                me = exp_q.pop_front();
                checks = checks + 1;
                if (me.cyc != cyc || got !== me.v) begin
                    errors = errors + 1;
                    $display("FAIL ph%0d cyc=%0d got rst/hs/vs/de=%b x=%0d y=%0d ls/fs=%b exp rst/hs/vs/de=%b x=%0d y=%0d ls/fs=%b",
                             me.tag, cyc, got[25:22], got[21:12], got[11:2], got[1:0],
                             me.v[25:22], me.v[21:12], me.v[11:2], me.v[1:0]);
                end
            end
        end
    end

    initial begin
        n_hs = 0; n_vs = 0; n_de = 0; n_ls = 0; n_fs = 0;
        last_fs = 0; fs_period = 0;
        win_lo = -1; win_hi = -2;
        forever begin
            @(negedge clock);
            if (cyc >= win_lo && cyc <= win_hi) begin
                if (!vga.hsync)     n_hs = n_hs + 1;
                if (!vga.vsync)     n_vs = n_vs + 1;
                if (vga.de)         n_de = n_de + 1;
                if (vga.line_start) n_ls = n_ls + 1;
                if (vga.frame_start) n_fs = n_fs + 1;
            end
            if (vga.frame_start) begin
                if (last_fs > 0) fs_period = cyc - last_fs;
                last_fs = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got timeout exp completion", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [25:0] run_at(input int x, input int y);
        logic hs, vs, de;
        de = (x < HA) && (y < VA);
        hs = !((x >= HA + HF) && (x < HA + HF + HS));
        vs = !((y >= VA + VF) && (y < VA + VF + VS));
        return {1'b0, hs, vs, de, 10'(x), 10'(y), (x == 0), (x == 0) && (y == 0)};
    endfunction

    task automatic tick(input logic r, input logic l, input logic [25:0] v, input int tag);
        exp_t e;
        reset      = r;
        pll_locked = l;
        e.cyc = cyc + 1;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic adv(input int n, input int tag);
        repeat (n) begin
            px = px + 1;
            if (px == HT) begin
                px = 0;
                py = (py == VT - 1) ? 0 : py + 1;
            end
            tick(1'b0, 1'b1, run_at(px, py), tag);
        end
    endtask

    task automatic chk(input string name, input int g, input int x);
        checks = checks + 1;
        if (g != x) begin
            errors = errors + 1;
            $display("FAIL %s got %0d exp %0d", name, g, x);
        end
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b1;
        px = 0;
        py = 0;
        @(posedge clock);
        #1;

        // Reset dominates a steady lock; then the full lock count must elapse.
        repeat (3) tick(1'b1, 1'b1, IDLE, 1);
        repeat (8) tick(1'b0, 1'b1, IDLE, 1);
        win_lo = cyc + 1;
        win_hi = cyc + FRAME;
        tick(1'b0, 1'b1, run_at(0, 0), 1);

        // One full frame and the wrap back to (0,0), then on to (300,10).
        adv(FRAME, 3);
        adv(10 * HT + 300, 4);

        chk("hsync_low_cycles", n_hs, 96 * VT);
        chk("vsync_low_cycles", n_vs, 1600);
        chk("de_cycles",        n_de, HA * VA);
        chk("line_starts",      n_ls, VT);
        chk("frame_starts",     n_fs, 1);
        chk("frame_period",     fs_period, FRAME);

        // Lock loss mid-frame, relock restarts at (0,0).
        tick(1'b0, 1'b0, IDLE, 5);
        repeat (8) tick(1'b0, 1'b1, IDLE, 5);
        px = 0;
        py = 0;
        tick(1'b0, 1'b1, run_at(0, 0), 5);

        // Reset inside the hsync pulse with lock still high.
        adv(700, 6);
        repeat (3) tick(1'b1, 1'b1, IDLE, 6);

        // One-cycle lock glitch after a few stable cycles restarts the count.
        repeat (5) tick(1'b0, 1'b1, IDLE, 2);
        tick(1'b0, 1'b0, IDLE, 2);
        repeat (8) tick(1'b0, 1'b1, IDLE, 2);
        px = 0;
        py = 0;
        tick(1'b0, 1'b1, run_at(0, 0), 2);
        adv(5, 2);

        repeat (3) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
